// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner for DIGITS BCD/hex digits.
// A shadow register is promoted to the display only at frame boundaries, so a frame never tears.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int HEX      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  pending
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]         tick_q, tick_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d, shadow_q, shadow_d;
  logic                  disp_lz_q, disp_lz_d, shadow_lz_q, shadow_lz_d;
  logic                  pending_q, pending_d;
  logic                  tick_last_s, idx_last_s, frame_s;
  logic [3:0]            code_s;
  logic                  nz_above_s, blank_s;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:  g = 7'h7E;
      4'd1:  g = 7'h30;
      4'd2:  g = 7'h6D;
      4'd3:  g = 7'h79;
      4'd4:  g = 7'h33;
      4'd5:  g = 7'h5B;
      4'd6:  g = 7'h5F;
      4'd7:  g = 7'h70;
      4'd8:  g = 7'h7F;
      4'd9:  g = 7'h7B;
      4'd10: g = (HEX != 0) ? 7'h77 : 7'h00;
      4'd11: g = (HEX != 0) ? 7'h1F : 7'h00;
      4'd12: g = (HEX != 0) ? 7'h4E : 7'h00;
      4'd13: g = (HEX != 0) ? 7'h3D : 7'h00;
      4'd14: g = (HEX != 0) ? 7'h4F : 7'h00;
      4'd15: g = (HEX != 0) ? 7'h47 : 7'h00;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign tick_last_s = (tick_q == TW'(PRESCALE - 1));
  assign idx_last_s  = (idx_q == IW'(DIGITS - 1));
  assign frame_s     = tick_last_s && idx_last_s;

  always_comb begin
    tick_d      = tick_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    disp_lz_d   = disp_lz_q;
    shadow_d    = shadow_q;
    shadow_lz_d = shadow_lz_q;
    pending_d   = pending_q;
    if (tick_last_s) begin
      tick_d = '0;
      idx_d  = idx_last_s ? '0 : idx_q + IW'(1);
    end else begin
      tick_d = tick_q + TW'(1);
    end
    if (frame_s && pending_q) begin
      disp_d    = shadow_q;
      disp_lz_d = shadow_lz_q;
      pending_d = 1'b0;
    end else begin
      disp_d = disp_q;
    end
    // A load on the boundary cycle wins over the clear, keeping the new value pending.
    if (load) begin
      shadow_d    = value;
      shadow_lz_d = blank_lz;
      pending_d   = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      disp_lz_q   <= 1'b0;
      shadow_q    <= '0;
      shadow_lz_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_lz_q   <= disp_lz_d;
      shadow_q    <= shadow_d;
      shadow_lz_q <= shadow_lz_d;
      pending_q   <= pending_d;
    end
  end

  // Codes 10..15 count as nonzero for blanking even when rendered dark.
  always_comb begin
    code_s     = 4'd0;
    nz_above_s = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx_q) code_s = disp_q[4*j +: 4];
      else                 code_s = code_s;
      if ((IW'(j) >= idx_q) && (disp_q[4*j +: 4] != 4'd0)) nz_above_s = 1'b1;
      else                                                  nz_above_s = nz_above_s;
    end
    blank_s = disp_lz_q && (idx_q != '0) && !nz_above_s;
  end

  assign seg     = blank_s ? 7'h00 : glyph(code_s);
  assign an      = DIGITS'(1) << idx_q;
  assign pending = pending_q;

endmodule
